// File: rtl/piece_move_ctrl.sv
// Active-piece move sequencer: arbitrate, build candidate, kick, board check.
// Optional hard drop is enabled by defining PIECE_HARD_DROP_EN.
module piece_move_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn,
    input  logic [3:0] spawn_x1,
    input  logic [3:0] spawn_x2,
    input  logic [3:0] spawn_x3,
    input  logic [3:0] spawn_x4,
    input  logic [4:0] spawn_y1,
    input  logic [4:0] spawn_y2,
    input  logic [4:0] spawn_y3,
    input  logic [4:0] spawn_y4,
    input  logic       req_left,
    input  logic       req_right,
    input  logic       req_rot,
    input  logic       req_drop,
    input  logic       grav_tick,
    input  logic [3:0] rot_x1,
    input  logic [3:0] rot_x2,
    input  logic [3:0] rot_x3,
    input  logic [3:0] rot_x4,
    input  logic [4:0] rot_y1,
    input  logic [4:0] rot_y2,
    input  logic [4:0] rot_y3,
    input  logic [4:0] rot_y4,
    output logic [3:0] board_rd_x,
    output logic [4:0] board_rd_y,
    input  logic       board_occ,
    output logic [3:0] px1,
    output logic [3:0] px2,
    output logic [3:0] px3,
    output logic [3:0] px4,
    output logic [4:0] py1,
    output logic [4:0] py2,
    output logic [4:0] py3,
    output logic [4:0] py4,
    output logic       piece_valid,
    output logic       busy,
    output logic       move_ok,
    output logic       move_rej,
    output logic       lock_pulse
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DECIDE = 3'd4;

    localparam int OP_L   = 0;
    localparam int OP_R   = 1;
    localparam int OP_ROT = 2;
    localparam int OP_DN  = 3;

    localparam logic [3:0] XMAX = 4'(COLS - 1);
    localparam logic [4:0] YMAX = 5'(ROWS - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] nidx;
    logic       bad_q, bad_d;
    logic       valid_q, valid_d;
    logic [3:0] rdx_q, rdx_d;
    logic [4:0] rdy_q, rdy_d;
    logic [3:0] px_q [4];
    logic [3:0] px_d [4];
    logic [4:0] py_q [4];
    logic [4:0] py_d [4];
    logic [3:0] cx_q [4];
    logic [3:0] cx_d [4];
    logic [4:0] cy_q [4];
    logic [4:0] cy_d [4];
    logic [3:0] nx [4];
    logic [4:0] ny [4];
    logic [3:0] sx [4];
    logic [4:0] sy [4];
    logic [3:0] rx [4];
    logic [4:0] ry [4];
    logic       kick_hi, kick_over, oob;
    logic [3:0] inc, req_all;
    logic       drop_q;
    logic       dec;

`ifdef PIECE_HARD_DROP_EN
    logic dpend_q, dpend_d, drop_d, dreq;
    assign dreq = dpend_q | (req_drop & valid_q);
`else
    logic unused_drop;
    assign unused_drop = req_drop;
    assign drop_q      = 1'b0;
`endif

    assign sx = '{spawn_x1, spawn_x2, spawn_x3, spawn_x4};
    assign sy = '{spawn_y1, spawn_y2, spawn_y3, spawn_y4};
    assign rx = '{rot_x1, rot_x2, rot_x3, rot_x4};
    assign ry = '{rot_y1, rot_y2, rot_y3, rot_y4};

    // Left+right in the same cycle cancel and are never latched.
    assign inc[OP_L]   = req_left & ~req_right & valid_q;
    assign inc[OP_R]   = req_right & ~req_left & valid_q;
    assign inc[OP_ROT] = req_rot & valid_q;
    assign inc[OP_DN]  = grav_tick & valid_q;
    assign req_all     = pend_q | inc;
    assign nidx        = idx_q + 2'd1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nx[i] = px_q[i];
            ny[i] = py_q[i];
        end
        unique case (1'b1)
            op_q[OP_L]:   for (int i = 0; i < 4; i++) nx[i] = px_q[i] - 4'd1;
            op_q[OP_R]:   for (int i = 0; i < 4; i++) nx[i] = px_q[i] + 4'd1;
            op_q[OP_DN]:  for (int i = 0; i < 4; i++) ny[i] = py_q[i] + 5'd1;
            op_q[OP_ROT]: begin
                for (int i = 0; i < 4; i++) begin
                    nx[i] = rx[i];
                    ny[i] = ry[i];
                end
            end
            default: ;
        endcase
        kick_hi   = 1'b0;
        kick_over = 1'b0;
        for (int i = 0; i < 4; i++) begin
            kick_hi   = kick_hi | (nx[i] >= 4'd14);
            kick_over = kick_over | (nx[i] > XMAX);
        end
        // Single kick: underflowed columns shift right, overflow shifts left.
        if (op_q[OP_ROT]) begin
            if (kick_hi) begin
                for (int i = 0; i < 4; i++) nx[i] = nx[i] + 4'd1;
            end else if (kick_over) begin
                for (int i = 0; i < 4; i++) nx[i] = nx[i] - 4'd1;
            end
        end
        oob = 1'b0;
        for (int i = 0; i < 4; i++) begin
            oob = oob | (nx[i] > XMAX) | (ny[i] > YMAX);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        valid_d = valid_q;
        rdx_d   = rdx_q;
        rdy_d   = rdy_q;
        pend_d  = pend_q | inc;
        for (int i = 0; i < 4; i++) begin
            px_d[i] = px_q[i];
            py_d[i] = py_q[i];
            cx_d[i] = cx_q[i];
            cy_d[i] = cy_q[i];
        end
`ifdef PIECE_HARD_DROP_EN
        dpend_d = dpend_q | (req_drop & valid_q);
        drop_d  = drop_q;
`endif
        if (spawn) begin
            state_d = S_IDLE;
            pend_d  = '0;
            valid_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
                px_d[i] = sx[i];
                py_d[i] = sy[i];
            end
`ifdef PIECE_HARD_DROP_EN
            dpend_d = 1'b0;
            drop_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    op_d    = '0;
                    state_d = S_CALC;
                    if (req_all[OP_DN]) begin
                        op_d[OP_DN]   = 1'b1;
                        pend_d[OP_DN] = 1'b0;
                    end
`ifdef PIECE_HARD_DROP_EN
                    else if (dreq) begin
                        op_d[OP_DN] = 1'b1;
                        drop_d      = 1'b1;
                        dpend_d     = 1'b0;
                    end
`endif
                    else if (req_all[OP_ROT]) begin
                        op_d[OP_ROT]   = 1'b1;
                        pend_d[OP_ROT] = 1'b0;
                    end else if (req_all[OP_L]) begin
                        op_d[OP_L]   = 1'b1;
                        pend_d[OP_L] = 1'b0;
                    end else if (req_all[OP_R]) begin
                        op_d[OP_R]   = 1'b1;
                        pend_d[OP_R] = 1'b0;
                    end else begin
                        op_d    = op_q;
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    for (int i = 0; i < 4; i++) begin
                        cx_d[i] = nx[i];
                        cy_d[i] = ny[i];
                    end
                    bad_d = oob;
                    idx_d = 2'd0;
                    if (oob) begin
                        state_d = S_DECIDE;
                    end else begin
                        state_d = S_CHECK;
                        rdx_d   = nx[0];
                        rdy_d   = ny[0];
                    end
                end
                S_CHECK: begin
                    if (idx_q != 2'd0) bad_d = bad_q | board_occ;
                    idx_d = nidx;
                    if (idx_q == 2'd3) begin
                        state_d = S_WAIT;
                    end else begin
                        rdx_d = cx_q[nidx];
                        rdy_d = cy_q[nidx];
                    end
                end
                S_WAIT: begin
                    bad_d   = bad_q | board_occ;
                    state_d = S_DECIDE;
                end
                S_DECIDE: begin
                    state_d = S_IDLE;
                    if (!bad_q) begin
                        for (int i = 0; i < 4; i++) begin
                            px_d[i] = cx_q[i];
                            py_d[i] = cy_q[i];
                        end
                        if (drop_q) state_d = S_CALC;
                    end else if (op_q[OP_DN]) begin
                        valid_d = 1'b0;
                        pend_d  = '0;
`ifdef PIECE_HARD_DROP_EN
                        dpend_d = 1'b0;
                        drop_d  = 1'b0;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            valid_q <= 1'b0;
            rdx_q   <= '0;
            rdy_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
                cx_q[i] <= '0;
                cy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            valid_q <= valid_d;
            rdx_q   <= rdx_d;
            rdy_q   <= rdy_d;
            for (int i = 0; i < 4; i++) begin
                px_q[i] <= px_d[i];
                py_q[i] <= py_d[i];
                cx_q[i] <= cx_d[i];
                cy_q[i] <= cy_d[i];
            end
        end
    end

`ifdef PIECE_HARD_DROP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dpend_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            dpend_q <= dpend_d;
            drop_q  <= drop_d;
        end
    end
`endif

    assign dec        = (state_q == S_DECIDE) & ~spawn;
    assign move_ok    = dec & ~bad_q & ~drop_q;
    assign move_rej   = dec & bad_q & ~op_q[OP_DN];
    assign lock_pulse = dec & bad_q & op_q[OP_DN];

    assign busy        = (state_q != S_IDLE);
    assign piece_valid = valid_q;
    assign board_rd_x  = rdx_q;
    assign board_rd_y  = rdy_q;
    assign px1 = px_q[0];
    assign px2 = px_q[1];
    assign px3 = px_q[2];
    assign px4 = px_q[3];
    assign py1 = py_q[0];
    assign py2 = py_q[1];
    assign py3 = py_q[2];
    assign py4 = py_q[3];

endmodule
